// File: rtl/receiver_if.sv
// Serial receive bundle: the RsRx line in, the received byte and status strobes out.
// The receiver takes the slave side; user logic or a bench takes the master side.
interface receiver_if;
  logic       RsRx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport slave  (input RsRx, output data, valid, frame_err, busy);
  modport master (output RsRx, input data, valid, frame_err, busy);
endinterface

// File: rtl/receiver.sv
// 8N1 UART receiver: two-flop synchroniser, falling-edge start detect and mid-bit sampling.
// It emits a one-cycle valid strobe for a good frame and a one-cycle frame_err strobe for a bad stop bit.
module receiver #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic     clk,
  input  logic     reset,
  receiver_if.slave rx
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  // The line idles high, so the synchroniser resets to 1 and no false start edge appears on reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
      rx_meta_q <= rx.RsRx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s_q) state_d = START;
      end
      START: begin
        // At the middle of the start bit, a line that has already returned high was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx.data      = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: frames are predicted from the sampling-time rule when driven,
// and a separate monitor checks every valid or frame_err pulse against the queued prediction.
module tb_receiver;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  logic reset;
  receiver_if bus ();

  receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line level t cycles after the start bit begins, for bits of bt cycles each.
  function automatic bit line_at(input int t, input int bt, input logic [7:0] b,
                                 input bit stop, input bit after);
    int idx;
    idx = t / bt;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9) return stop;
    return after;
  endfunction

  task automatic drive(input bit v, input int n);
    bus.RsRx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // The receiver samples at HALF + (k+1)*CPB after the start edge regardless of the sender's rate;
  // the outcome follows from which driven bit sits under each sample point.
  task automatic send(input logic [7:0] b, input bit stop, input int bt,
                      input int gap, input bit after);
    exp_t       e;
    logic [7:0] got;
    bit         s_stop;
    for (int k = 0; k < 8; k++) got[k] = line_at(HALF + (k + 1) * CPB, bt, b, stop, after);
    s_stop = line_at(HALF + 9 * CPB, bt, b, stop, after);
    e.err  = !s_stop;
    e.data = e.err ? last_good : got;
    if (!e.err) last_good = got;
    e.at = cyc + 2 + HALF + 9 * CPB + 1;
    sb.push_back(e);
    drive(1'b0, bt);
    for (int k = 0; k < 8; k++) drive(b[k], bt);
    drive(stop, bt);
    if (gap > 0) drive(after, gap);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (bus.valid || bus.frame_err)) begin
        check("pulse_exclusive", int'(bus.valid && bus.frame_err), 0);
        check("pulse_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("pulse_kind_err", int'(bus.frame_err), int'(e.err));
          check("pulse_data", int'(bus.data), int'(e.data));
          check("pulse_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin : stim
    int         n0;
    int         t;
    logic [7:0] b;
    bit         stop;
    int         gap;
    logic [7:0] pats[3] = '{8'h00, 8'hFF, 8'h5A};
    int         rates[2] = '{15, 17};

    bus.RsRx = 1'b1;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", int'(bus.data), 0);
    check("reset_valid", int'(bus.valid), 0);
    check("reset_frame_err", int'(bus.frame_err), 0);
    check("reset_busy", int'(bus.busy), 0);
    reset = 1'b0;
    drive(1'b1, 2 * CPB);

    // Back-to-back frames with no idle gap; the pulse cycle check covers the latency.
    send(8'h55, 1'b1, CPB, 0, 1'b1);
    send(8'hA3, 1'b1, CPB, 2 * CPB, 1'b1);

    // A 3-cycle low glitch is rejected at the start-bit midpoint.
    n0 = cyc;
    drive(1'b0, 3);
    drive(1'b1, 2);
    check("glitch_busy_high", int'(bus.busy), 1);
    drive(1'b1, 6);
    check("glitch_busy_dropped", int'(bus.busy), 0);
    check("glitch_elapsed", cyc - n0, 11);
    drive(1'b1, CPB);

    // Bad stop bit followed by a long break, then a good frame.
    send(8'h3C, 1'b0, CPB, 40 * CPB, 1'b0);
    drive(1'b1, 2 * CPB);
    send(8'h81, 1'b1, CPB, 2 * CPB, 1'b1);
    check("data_after_break", int'(bus.data), 8'h81);

    // Reset asserted after data bit 4 of 0xFF discards the frame.
    drive(1'b0, CPB);
    for (int k = 0; k < 5; k++) drive(1'b1, CPB);
    reset = 1'b1;
    #1;
    check("midreset_data", int'(bus.data), 0);
    check("midreset_busy", int'(bus.busy), 0);
    check("midreset_valid", int'(bus.valid), 0);
    drive(1'b1, 2);
    reset     = 1'b0;
    last_good = 8'h00;
    drive(1'b1, 6 * CPB);
    send(8'h12, 1'b1, CPB, 2 * CPB, 1'b1);

    // Sender running at 15 and 17 clocks per bit.
    foreach (rates[r]) begin
      foreach (pats[p]) send(pats[p], 1'b1, rates[r], 3 * CPB, 1'b1);
    end

    // Random bytes, occasional bad stop bits, random idle gaps.
    repeat (24) begin
      b    = 8'($urandom);
      stop = ($urandom_range(7) != 0);
      gap  = stop ? int'($urandom_range(40)) : int'($urandom_range(3 * CPB, CPB));
      send(b, stop, CPB, gap, 1'b1);
    end

    t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
